// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC fetch-sequencing controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    EXEC = 2'd3
  } pc_state_e;

  localparam logic PCSRC_INC    = 1'b0;
  localparam logic PCSRC_BRANCH = 1'b1;

  // A boot hold of zero would never leave BOOT, so it is promoted to one.
  function automatic int boot_load(input int hold);
    return (hold < 1) ? 1 : hold;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Handshake, decode and status bundle between pc_fetch_ctrl and its neighbours.
interface pc_fetch_ctrl_if #(
  parameter int CNT_W = 32
);

  logic             imem_req;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic             branch;
  logic             eq;
  logic             stall;
  logic             instr_valid;
  logic             PCsrc;
  logic             pc_en;
  logic             busy;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  imem_gnt, imem_rvalid, branch, eq, stall,
    output imem_req, instr_valid, PCsrc, pc_en, busy, retired_cnt, stall_cnt
  );

  modport slave (
    output imem_gnt, imem_rvalid, branch, eq, stall,
    input  imem_req, instr_valid, PCsrc, pc_en, busy, retired_cnt, stall_cnt
  );

endinterface

// File: rtl/pc_perf_cnt.sv
// Saturating event counter; holds at all-ones until reset.
module pc_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: BOOT -> REQ -> WAIT -> EXEC, one instruction at a time.
// Performance counters are built only when PC_FETCH_CTRL_PERF_EN is defined.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int BOOT_HOLD = 2,
  parameter int CNT_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_ctrl_if.master bus
);

  localparam int BOOT_LOAD = boot_load(BOOT_HOLD);
  localparam int BOOT_W    = $clog2(BOOT_LOAD + 1);

  pc_state_e         state;
  pc_state_e         state_next;
  logic [BOOT_W-1:0] boot_cnt;
  logic              boot_done;
  logic              imem_req;
  logic              instr_valid;
  logic              pc_en;
  logic              pc_src;
  logic              busy;

  assign boot_done = (boot_cnt == BOOT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      boot_cnt <= BOOT_W'(BOOT_LOAD);
    end else begin
      state <= state_next;
      if ((state == BOOT) && !boot_done) begin
        boot_cnt <= boot_cnt - BOOT_W'(1);
      end
    end
  end

  // pc_en and PCsrc are Mealy in EXEC; PCsrc can only be non-zero while pc_en is high.
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    pc_en       = 1'b0;
    pc_src      = PCSRC_INC;
    busy        = 1'b0;
    case (state)
      BOOT: begin
        if (boot_done) state_next = REQ;
      end
      REQ: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (bus.imem_gnt) state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (bus.imem_rvalid) state_next = EXEC;
      end
      EXEC: begin
        busy        = 1'b1;
        instr_valid = 1'b1;
        if (!bus.stall) begin
          pc_en      = 1'b1;
          pc_src     = (bus.branch && bus.eq) ? PCSRC_BRANCH : PCSRC_INC;
          state_next = REQ;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  assign bus.imem_req    = imem_req;
  assign bus.instr_valid = instr_valid;
  assign bus.pc_en       = pc_en;
  assign bus.PCsrc       = pc_src;
  assign bus.busy        = busy;

`ifdef PC_FETCH_CTRL_PERF_EN
  logic stall_inc;
  assign stall_inc = (state == EXEC) && bus.stall;

  pc_perf_cnt #(.CNT_W(CNT_W)) u_retired_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pc_en),
    .cnt (bus.retired_cnt)
  );

  pc_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (bus.stall_cnt)
  );
`else
  assign bus.retired_cnt = '0;
  assign bus.stall_cnt   = '0;
`endif

endmodule
